pll_lock_checker: RTL and testbench
===================================

Name: pll_lock_checker

Overview:
- Reusable, synthesizable lock-integrity checker for multi-output PLL benches and on-chip health monitoring.
- Monitors N_CH asynchronous pll_lock lines and filters glitches.
- Detects lock timeout, lock loss and failed relock per channel.
- Reports sticky per-channel error flags, a saturating global error count and per-channel loss counters.

Parameters:
- N_CH, 4, number of monitored lock inputs (1..16)
- STABLE_CYC, 8, consecutive synchronized-high cycles required to declare lock (>=1)
- LOCK_TIMEOUT, 1000, cycles allowed from arm or loss until lock is declared (>=STABLE_CYC)
- ALLOW_RELOCK, 1, 1: loss is an error only if relock misses LOCK_TIMEOUT; 0: every loss is an error
- CNT_W, 4, width of per-channel loss counter
- ERR_W, 3, width of global error counter

Ports:
- clk_tb  in  1  monitor clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle arm pulse, issued after PLL reset release
- pll_lock  in  N_CH  raw lock inputs, asynchronous to clk_tb
- err_clr  in  1  single-cycle clear of flags and counters
- ch_sel  in  $clog2(N_CH) (min 1)  channel select for loss_cnt
- locked  out  N_CH  filtered lock status
- err_flag  out  N_CH  sticky per-channel error
- timeout_flag  out  N_CH  sticky per-channel timeout cause
- err_any  out  1  OR of err_flag
- err_cnt  out  ERR_W  saturating count of error cycles
- loss_cnt  out  CNT_W  loss count of channel ch_sel; combinational mux of registered counters

Behaviour:
- Reset: all outputs 0, all channel FSMs in IDLE, all counters and timers 0.
- Input path:
  - Each pll_lock bit passes a 2-FF synchronizer (lock_s).
  - A stability counter counts consecutive lock_s=1 and clears on lock_s=0.
  - "stable" is true once the counter reaches STABLE_CYC; the counter saturates there.
- Per-channel FSM:
  - IDLE: no checking. start -> WAIT; timer cleared.
  - WAIT: timer increments each cycle. stable -> LOCK, with locked=1 from the next cycle. Timer reaching LOCK_TIMEOUT -> error event, timeout_flag set, timer saturates, remain in WAIT.
  - LOCK: lock_s=0 -> LOST, locked=0 next cycle, loss counter +1 (saturating at all-ones), timer cleared. If ALLOW_RELOCK=0 the loss is also an error event.
  - LOST: same as WAIT (relock -> LOCK; timeout -> error event plus timeout_flag).
- Latency:
  - A clean lock edge gives locked=1 exactly 2+STABLE_CYC cycles after the pll_lock rise is sampled.
  - A loss gives locked=0 exactly 3 cycles after the fall is sampled.
- Glitches: a high pulse shorter than STABLE_CYC cycles never asserts locked. While in LOCK, any synchronized low cycle counts as a loss.
- Error event for a channel sets its err_flag (sticky).
- err_cnt:
  - Increments by 1 in any cycle where at least one channel has an error event, regardless of how many channels fire that cycle.
  - Saturates at all-ones, with no wrap-around.
- start while active: every FSM restarts in WAIT and timers clear. Flags and counters are kept.
- err_clr:
  - Clears err_flag, timeout_flag, err_cnt and all loss counters.
  - Does not change FSM state or locked.
  - If an error event occurs in the same cycle, the event wins: the flag is set and err_cnt=1.
- start and err_clr in the same cycle: both take effect.
- rst_n asserted mid-operation returns everything to reset values immediately. The synchronizers also clear.
- err_any is registered as the OR of the next-state err_flag, so it aligns with err_flag.

Decomposition:
- Package pll_chk_pkg holds:
  - channel state enum (IDLE, WAIT, LOCK, LOST), 2-bit encoding
  - a saturating-increment function
- Sub-module pll_lock_ch implements synchronizer, stability filter, timer, FSM and loss counter for one channel. It is generate-instantiated N_CH times.
- Top level holds err_cnt, err_any and the loss_cnt mux.

Test Plan:
- Clean lock: start, then pll_lock[3:0] rises 100 cycles later and stays high -> locked=4'hF at cycle +110, err_any=0, err_cnt=0.
- Glitch reject: after start, ch0 high for 5 cycles then low, then high at cycle 200 -> locked[0] asserts only after the second rise, loss_cnt(ch0)=0, no error.
- Timeout: start with ch2 held low -> at timer=1000, err_flag=4'b0100, timeout_flag[2]=1, err_cnt=1. Raising ch2 later gives locked[2]=1 and the flags stay set.
- Loss/relock, ALLOW_RELOCK=1: locked ch1 drops for 20 cycles then returns -> loss_cnt(ch1)=1, no error. Repeating with ALLOW_RELOCK=0 -> err_flag[1]=1, err_cnt=1.
- Saturation and clear: force 9 separate error cycles with ERR_W=3 -> err_cnt=7. err_clr coinciding with a new error -> err_cnt=1, flag set.
- Async reset mid-LOCK: drop rst_n for 3 ns -> all outputs 0 immediately. With no start, locked stays 0 even though pll_lock is high.

Source files
------------

// File: rtl/pll_chk_pkg.sv
// Shared types and helpers for the PLL lock checker: per-channel state
// encoding and a saturating increment used by all counters.
package pll_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOCK = 2'd2,
        ST_LOST = 2'd3
    } ch_state_t;

    // Increment that sticks at max_val; callers size the result back down.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_ch.sv
// One monitored lock line: 2-FF synchronizer, stability filter, lock timer,
// channel FSM, loss counter and sticky error/timeout flags.
module pll_lock_ch
    import pll_chk_pkg::*;
#(
    parameter int STABLE_CYC   = 8,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int ALLOW_RELOCK = 1,
    parameter int CNT_W        = 4
) (
    input  logic             clk_tb,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pll_lock,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_flag,
    output logic             err_flag_next,
    output logic             timeout_flag,
    output logic             err_evt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYC);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(LOCK_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LOSS_MAX  = '1;

    logic              sync1_reg;
    logic              sync2_reg;
    logic [STAB_W-1:0] stab_cnt_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [TMR_W-1:0]  timer_next;
    ch_state_t         state_reg;
    ch_state_t         state_next;
    logic              locked_reg;
    logic              err_flag_reg;
    logic              tmo_flag_reg;
    logic              tmo_flag_next;
    logic              tmo_evt;
    logic              loss_evt;
    logic [CNT_W-1:0]  loss_cnt_reg;
    logic [CNT_W-1:0]  loss_cnt_next;
    logic              stable;

    assign stable = (stab_cnt_reg == STAB_MAX);

    // The raw line is asynchronous; nothing downstream looks at sync1_reg.
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            stab_cnt_reg <= '0;
        end else begin
            sync1_reg <= pll_lock;
            sync2_reg <= sync1_reg;
            if (!sync2_reg)
                stab_cnt_reg <= '0;
            else if (!stable)
                stab_cnt_reg <= STAB_W'(sat_inc(32'(stab_cnt_reg), 32'(STAB_MAX)));
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            locked_reg   <= 1'b0;
            err_flag_reg <= 1'b0;
            tmo_flag_reg <= 1'b0;
            loss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            locked_reg   <= (state_next == ST_LOCK);
            err_flag_reg <= err_flag_next;
            tmo_flag_reg <= tmo_flag_next;
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        err_evt    = 1'b0;
        tmo_evt    = 1'b0;
        loss_evt   = 1'b0;

        case (state_reg)
            ST_IDLE: ;
            ST_WAIT, ST_LOST: begin
                // A lock declared on the same cycle the timer expires wins.
                if (stable) begin
                    state_next = ST_LOCK;
                end else if (timer_reg != TMR_MAX) begin
                    timer_next = timer_reg + TMR_W'(1);
                    if (timer_reg == TMR_LAST) begin
                        err_evt = 1'b1;
                        tmo_evt = 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                // stable drops one cycle after any synchronized low sample.
                if (!stable) begin
                    state_next = ST_LOST;
                    timer_next = '0;
                    loss_evt   = 1'b1;
                    err_evt    = (ALLOW_RELOCK == 0);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (start) begin
            state_next = ST_WAIT;
            timer_next = '0;
        end

        // A same-cycle event survives a clear.
        if (err_clr) begin
            err_flag_next = err_evt;
            tmo_flag_next = tmo_evt;
            loss_cnt_next = loss_evt ? CNT_W'(1) : '0;
        end else begin
            err_flag_next = err_flag_reg | err_evt;
            tmo_flag_next = tmo_flag_reg | tmo_evt;
            loss_cnt_next = loss_evt
                ? CNT_W'(sat_inc(32'(loss_cnt_reg), 32'(LOSS_MAX)))
                : loss_cnt_reg;
        end
    end

    assign locked       = locked_reg;
    assign err_flag     = err_flag_reg;
    assign timeout_flag = tmo_flag_reg;
    assign loss_cnt     = loss_cnt_reg;

endmodule

// File: rtl/pll_lock_checker.sv
// Multi-channel PLL lock checker: one pll_lock_ch per input plus the shared
// error counter, error summary and loss-counter read mux.
module pll_lock_checker
    import pll_chk_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int STABLE_CYC   = 8,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int ALLOW_RELOCK = 1,
    parameter int CNT_W        = 4,
    parameter int ERR_W        = 3,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_tb,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  pll_lock,
    input  logic             err_clr,
    input  logic [SEL_W-1:0] ch_sel,
    output logic [N_CH-1:0]  locked,
    output logic [N_CH-1:0]  err_flag,
    output logic [N_CH-1:0]  timeout_flag,
    output logic             err_any,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [N_CH-1:0]  err_flag_next_vec;
    logic [N_CH-1:0]  err_evt_vec;
    logic [CNT_W-1:0] loss_cnt_ch [N_CH];
    logic [ERR_W-1:0] err_cnt_reg;
    logic             err_any_reg;
    logic             any_evt;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            pll_lock_ch #(
                .STABLE_CYC   (STABLE_CYC),
                .LOCK_TIMEOUT (LOCK_TIMEOUT),
                .ALLOW_RELOCK (ALLOW_RELOCK),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk_tb        (clk_tb),
                .rst_n         (rst_n),
                .start         (start),
                .pll_lock      (pll_lock[gi]),
                .err_clr       (err_clr),
                .locked        (locked[gi]),
                .err_flag      (err_flag[gi]),
                .err_flag_next (err_flag_next_vec[gi]),
                .timeout_flag  (timeout_flag[gi]),
                .err_evt       (err_evt_vec[gi]),
                .loss_cnt      (loss_cnt_ch[gi])
            );
        end
    endgenerate

    // Simultaneous events on several channels still count as one error cycle.
    assign any_evt = |err_evt_vec;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
            err_any_reg <= 1'b0;
        end else begin
            if (err_clr)
                err_cnt_reg <= any_evt ? ERR_W'(1) : '0;
            else if (any_evt)
                err_cnt_reg <= ERR_W'(sat_inc(32'(err_cnt_reg), 32'(ERR_MAX)));
            err_any_reg <= |err_flag_next_vec;
        end
    end

    always_comb begin
        loss_cnt = '0;
        if (int'(ch_sel) < N_CH)
            loss_cnt = loss_cnt_ch[ch_sel];
    end

    assign err_cnt = err_cnt_reg;
    assign err_any = err_any_reg;

endmodule

// File: tb/tb_pll_lock_checker.sv
// Directed bench for pll_lock_checker: one instance with relock allowed and
// one that treats every loss as an error, both driven by the same stimulus.
module tb_pll_lock_checker;

    logic       clk_tb   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       err_clr  = 1'b0;
    logic [3:0] pll_lock = 4'h0;
    logic [1:0] ch_sel   = 2'd0;

    logic [3:0] a_locked, a_err_flag, a_tmo, a_loss;
    logic       a_err_any;
    logic [2:0] a_err_cnt;
    logic [3:0] b_locked, b_err_flag, b_tmo, b_loss;
    logic       b_err_any;
    logic [2:0] b_err_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk_tb = ~clk_tb;

    pll_lock_checker #(
        .N_CH(4), .STABLE_CYC(8), .LOCK_TIMEOUT(1000),
        .ALLOW_RELOCK(1), .CNT_W(4), .ERR_W(3)
    ) dut_relock (
        .clk_tb(clk_tb), .rst_n(rst_n), .start(start), .pll_lock(pll_lock),
        .err_clr(err_clr), .ch_sel(ch_sel), .locked(a_locked),
        .err_flag(a_err_flag), .timeout_flag(a_tmo), .err_any(a_err_any),
        .err_cnt(a_err_cnt), .loss_cnt(a_loss)
    );

    pll_lock_checker #(
        .N_CH(4), .STABLE_CYC(8), .LOCK_TIMEOUT(1000),
        .ALLOW_RELOCK(0), .CNT_W(4), .ERR_W(3)
    ) dut_strict (
        .clk_tb(clk_tb), .rst_n(rst_n), .start(start), .pll_lock(pll_lock),
        .err_clr(err_clr), .ch_sel(ch_sel), .locked(b_locked),
        .err_flag(b_err_flag), .timeout_flag(b_tmo), .err_any(b_err_any),
        .err_cnt(b_err_cnt), .loss_cnt(b_loss)
    );

    // Each tick leaves us 1 ns after the active edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_tb);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset(input logic [3:0] lock_val);
        rst_n    = 1'b0;
        pll_lock = lock_val;
        tick(3);
        rst_n = 1'b1;
        tick(12);
    endtask

    initial begin
        // Reset state
        do_reset(4'h0);
        expect_val("rst_locked", 0);   expect_val("rst_err_flag", 0);
        expect_val("rst_tmo", 0);      expect_val("rst_err_any", 0);
        expect_val("rst_err_cnt", 0);  expect_val("rst_loss", 0);
        check(32'(a_locked)); check(32'(a_err_flag)); check(32'(a_tmo));
        check(32'(a_err_any)); check(32'(a_err_cnt)); check(32'(a_loss));

        // Clean lock: rise sampled 100 cycles after start, locked 10 later
        pulse_start();
        tick(99);
        pll_lock = 4'hF;
        expect_val("clean_pre", 4'h0);
        tick(10);
        check(32'(a_locked));
        expect_val("clean_locked", 4'hF);
        expect_val("clean_err_any", 0);
        expect_val("clean_err_cnt", 0);
        expect_val("clean_strict_err_cnt", 0);
        tick(1);
        check(32'(a_locked)); check(32'(a_err_any));
        check(32'(a_err_cnt)); check(32'(b_err_cnt));

        // Glitch rejection on ch0
        do_reset(4'b1110);
        pulse_start();
        tick(10);
        pll_lock[0] = 1'b1;
        tick(5);
        pll_lock[0] = 1'b0;
        tick(184);
        pll_lock[0] = 1'b1;
        expect_val("glitch_pre", 4'b1110);
        tick(10);
        check(32'(a_locked));
        expect_val("glitch_locked", 4'hF);
        expect_val("glitch_loss_ch0", 0);
        expect_val("glitch_strict_err_any", 0);
        tick(1);
        check(32'(a_locked)); check(32'(a_loss)); check(32'(b_err_any));

        // Timeout on ch2
        do_reset(4'b1011);
        pulse_start();
        expect_val("tmo_pre_flag", 0);
        tick(999);
        check(32'(a_err_flag));
        expect_val("tmo_err_flag", 4'b0100);
        expect_val("tmo_flag", 4'b0100);
        expect_val("tmo_err_cnt", 1);
        expect_val("tmo_err_any", 1);
        expect_val("tmo_strict_err_cnt", 1);
        tick(1);
        check(32'(a_err_flag)); check(32'(a_tmo)); check(32'(a_err_cnt));
        check(32'(a_err_any)); check(32'(b_err_cnt));
        pll_lock[2] = 1'b1;
        expect_val("tmo_relock", 4'hF);
        expect_val("tmo_flag_kept", 4'b0100);
        tick(11);
        check(32'(a_locked)); check(32'(a_tmo));

        // Loss and relock on ch1
        ch_sel = 2'd1;
        pll_lock[1] = 1'b0;
        expect_val("loss_pre", 4'hF);
        tick(3);
        check(32'(a_locked));
        expect_val("loss_locked", 4'b1101);
        tick(1);
        check(32'(a_locked));
        tick(16);
        pll_lock[1] = 1'b1;
        expect_val("relock_locked", 4'hF);
        expect_val("relock_loss", 1);
        expect_val("relock_err_flag", 4'b0100);
        expect_val("relock_err_cnt", 1);
        expect_val("strict_loss_flag", 4'b0110);
        expect_val("strict_loss_cnt", 2);
        expect_val("strict_loss_ch1", 1);
        tick(11);
        check(32'(a_locked)); check(32'(a_loss)); check(32'(a_err_flag));
        check(32'(a_err_cnt)); check(32'(b_err_flag)); check(32'(b_err_cnt));
        check(32'(b_loss));

        // Clear leaves state and locked untouched
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        expect_val("clr_err_flag", 0); expect_val("clr_tmo", 0);
        expect_val("clr_err_cnt", 0);  expect_val("clr_err_any", 0);
        expect_val("clr_loss", 0);     expect_val("clr_locked", 4'hF);
        expect_val("clr_strict_err_cnt", 0);
        check(32'(a_err_flag)); check(32'(a_tmo)); check(32'(a_err_cnt));
        check(32'(a_err_any)); check(32'(a_loss)); check(32'(a_locked));
        check(32'(b_err_cnt));

        // Error counter saturation on the strict instance
        for (int i = 0; i < 7; i++) begin
            pll_lock[1] = 1'b0;
            tick(2);
            pll_lock[1] = 1'b1;
            tick(14);
        end
        expect_val("sat_cnt7", 7);
        check(32'(b_err_cnt));
        for (int i = 0; i < 2; i++) begin
            pll_lock[1] = 1'b0;
            tick(2);
            pll_lock[1] = 1'b1;
            tick(14);
        end
        expect_val("sat_cnt9", 7);
        expect_val("sat_strict_loss", 9);
        expect_val("sat_relock_err_cnt", 0);
        expect_val("sat_relock_loss", 9);
        check(32'(b_err_cnt)); check(32'(b_loss));
        check(32'(a_err_cnt)); check(32'(a_loss));

        // Clear coinciding with a new loss error
        pll_lock[1] = 1'b0;
        tick(3);
        err_clr = 1'b1;
        pll_lock[1] = 1'b1;
        tick(1);
        err_clr = 1'b0;
        expect_val("clrevt_err_cnt", 1);
        expect_val("clrevt_err_flag", 4'b0010);
        expect_val("clrevt_err_any", 1);
        expect_val("clrevt_loss", 1);
        expect_val("clrevt_relock_err_cnt", 0);
        expect_val("clrevt_relock_loss", 1);
        check(32'(b_err_cnt)); check(32'(b_err_flag)); check(32'(b_err_any));
        check(32'(b_loss)); check(32'(a_err_cnt)); check(32'(a_loss));

        // Asynchronous reset in the middle of LOCK
        tick(12);
        expect_val("arst_pre_locked", 4'hF);
        check(32'(a_locked));
        rst_n = 1'b0;
        #3;
        expect_val("arst_locked", 0);    expect_val("arst_strict_cnt", 0);
        expect_val("arst_strict_flag", 0); expect_val("arst_strict_any", 0);
        expect_val("arst_strict_loss", 0); expect_val("arst_strict_locked", 0);
        check(32'(a_locked)); check(32'(b_err_cnt)); check(32'(b_err_flag));
        check(32'(b_err_any)); check(32'(b_loss)); check(32'(b_locked));
        #3;
        rst_n = 1'b1;
        expect_val("nostart_locked", 0);
        expect_val("nostart_strict_locked", 0);
        tick(30);
        check(32'(a_locked)); check(32'(b_locked));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
